// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module  : tail_light_seq
// Brief   : Tick-paced tail-light sequencer (hazard / left / right sweep, brake overlay)
// Revision: 1.0 - initial release
// ============================================================================
module tail_light_seq #(
    parameter int LEDS_PER_SIDE = 3,
    parameter int STEP_TICKS    = 1,
    parameter int HAZ_TICKS     = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     hazard,
    input  logic                     turn,
    input  logic                     side,
    input  logic                     brake,
    output logic [LEDS_PER_SIDE-1:0] left_led,
    output logic [LEDS_PER_SIDE-1:0] right_led,
    output logic [2:0]               state,
    output logic                     busy
);

    localparam int c_N    = LEDS_PER_SIDE;
    localparam int c_SW   = $clog2(c_N + 1);
    localparam int c_TMAX = (STEP_TICKS > HAZ_TICKS) ? STEP_TICKS : HAZ_TICKS;
    localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    if (LEDS_PER_SIDE < 1 || LEDS_PER_SIDE > 16 || STEP_TICKS < 1 || HAZ_TICKS < 1) begin : g_param_check
        $error("tail_light_seq: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HAZARD = 3'd1,
        S_LEFT   = 3'd2,
        S_RIGHT  = 3'd3
    } state_e;

    state_e            r_state, w_next_state, w_req;
    logic [c_SW-1:0]   r_step, w_step_nxt;
    logic [c_TW-1:0]   r_tick_cnt, w_tick_nxt, w_tlim;
    logic              r_phase, w_phase_nxt;
    logic              r_brake;
    logic [c_N-1:0]    r_left_led, r_right_led, w_left, w_right;
    logic              r_busy;

    // Next-state and counter update; only a tick may move anything.
    always_comb begin
        w_next_state = r_state;
        w_step_nxt   = r_step;
        w_tick_nxt   = r_tick_cnt;
        w_phase_nxt  = r_phase;
        w_tlim       = (r_state == S_HAZARD) ? c_TW'(HAZ_TICKS - 1) : c_TW'(STEP_TICKS - 1);

        if (hazard)
            w_req = S_HAZARD;
        else if (turn && side)
            w_req = S_LEFT;
        else if (turn)
            w_req = S_RIGHT;
        else
            w_req = S_IDLE;

        if (tick) begin
            w_next_state = w_req;
            if (w_req != r_state) begin
                w_step_nxt  = '0;
                w_tick_nxt  = '0;
                w_phase_nxt = 1'b0;
            end else if (r_state != S_IDLE) begin
                if (r_tick_cnt == w_tlim) begin
                    w_tick_nxt = '0;
                    if (r_state == S_HAZARD)
                        w_phase_nxt = ~r_phase;
                    else if (r_step == c_SW'(c_N))
                        w_step_nxt = '0;
                    else
                        w_step_nxt = r_step + c_SW'(1);
                end else begin
                    w_tick_nxt = r_tick_cnt + c_TW'(1);
                end
            end
        end
    end

    // Pattern decode from the registered state; brake overlays the idle bank(s).
    always_comb begin
        w_left  = '0;
        w_right = '0;
        for (int i = 0; i < c_N; i++) begin
            w_left[i]  = (r_state == S_LEFT)  && (i < int'(r_step));
            w_right[i] = (r_state == S_RIGHT) && ((c_N - 1 - i) < int'(r_step));
        end
        if (r_state == S_HAZARD) begin
            w_left  = {c_N{r_phase}};
            w_right = {c_N{r_phase}};
        end
        if (r_brake) begin
            case (r_state)
                S_IDLE: begin
                    w_left  = '1;
                    w_right = '1;
                end
                S_LEFT:  w_right = '1;
                S_RIGHT: w_left  = '1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_tick_cnt  <= '0;
            r_phase     <= 1'b0;
            r_brake     <= 1'b0;
            r_left_led  <= '0;
            r_right_led <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_step      <= w_step_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_phase     <= w_phase_nxt;
            r_brake     <= brake;
            r_left_led  <= w_left;
            r_right_led <= w_right;
            r_busy      <= (r_state != S_IDLE);
        end
    end

    assign state     = r_state;
    assign left_led  = r_left_led;
    assign right_led = r_right_led;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tail_light_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_tail_light_seq
// Brief   : Two sequencer instances (N=3 and N=5) on shared stimulus vs. a tick-count model
// Revision: 1.0 - initial release
// ============================================================================
module tb_tail_light_seq;

    localparam int NA = 3, SA = 1, HA = 2;
    localparam int NB = 5, SB = 3, HB = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0, tick = 1'b0, hazard = 1'b0, turn = 1'b0, side = 1'b0, brake = 1'b0;
    logic [2:0] st_a, st_b, ll_a, rl_a;
    logic [4:0] ll_b, rl_b;
    logic busy_a, busy_b;
    logic [35:0] obs_a, obs_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: mode code plus ticks spent in that mode; step/phase derive arithmetically.
    int          m_mode [2];
    int          m_ticks[2];
    bit          m_brk  [2];
    logic [15:0] m_l    [2];
    logic [15:0] m_r    [2];
    bit          m_busy [2];

    always #5 clk = ~clk;

    tail_light_seq #(.LEDS_PER_SIDE(NA), .STEP_TICKS(SA), .HAZ_TICKS(HA)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .tick(tick), .hazard(hazard), .turn(turn),
        .side(side), .brake(brake), .left_led(ll_a), .right_led(rl_a), .state(st_a), .busy(busy_a)
    );

    tail_light_seq #(.LEDS_PER_SIDE(NB), .STEP_TICKS(SB), .HAZ_TICKS(HB)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .tick(tick), .hazard(hazard), .turn(turn),
        .side(side), .brake(brake), .left_led(ll_b), .right_led(rl_b), .state(st_b), .busy(busy_b)
    );

    assign obs_a = {st_a, busy_a, 13'd0, ll_a, 13'd0, rl_a};
    assign obs_b = {st_b, busy_b, 11'd0, ll_b, 11'd0, rl_b};

    function automatic logic [31:0] decode(int i, int mode, int ticks, bit brk);
        int n, st, pt;
        logic [15:0] all, mask, l, r;
        n  = (i == 0) ? NA : NB;
        st = (i == 0) ? SA : SB;
        pt = (i == 0) ? HA : HB;
        all = 16'((1 << n) - 1);
        l = '0;
        r = '0;
        if (mode == 2 || mode == 3) begin
            int step;
            step = (ticks / st) % (n + 1);
            mask = 16'((1 << step) - 1);
            if (mode == 2) l = mask;
            else           r = 16'(mask << (n - step));
        end else if (mode == 1) begin
            if (((ticks / pt) % 2) == 1) begin
                l = all;
                r = all;
            end
        end
        if (brk) begin
            if (mode == 0) begin
                l = all;
                r = all;
            end else if (mode == 2) begin
                r = all;
            end else if (mode == 3) begin
                l = all;
            end
        end
        return {l, r};
    endfunction

    function automatic logic [35:0] exp_vec(int i);
        return {3'(m_mode[i]), m_busy[i], m_l[i], m_r[i]};
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] d;
            int want;
            d = decode(i, m_mode[i], m_ticks[i], m_brk[i]);
            if (!reset_n) begin
                m_mode[i] = 0; m_ticks[i] = 0; m_brk[i] = 1'b0;
                m_l[i] = '0; m_r[i] = '0; m_busy[i] = 1'b0;
            end else begin
                m_l[i]    = d[31:16];
                m_r[i]    = d[15:0];
                m_busy[i] = (m_mode[i] != 0);
                m_brk[i]  = brake;
                if (tick) begin
                    want = hazard ? 1 : (turn && side) ? 2 : turn ? 3 : 0;
                    if (want != m_mode[i]) begin
                        m_mode[i]  = want;
                        m_ticks[i] = 0;
                    end else if (m_mode[i] != 0) begin
                        m_ticks[i]++;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; tick = 1'b0; hazard = 1'b0; turn = 1'b0; side = 1'b0; brake = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick = ((k % 4) == 3);
            cycle();
            vectors++;
            if ({st_a, busy_a, ll_a, rl_a} !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d got %b expected 0000000000", cyc, {st_a, busy_a, ll_a, rl_a});
            end
            vectors++;
            if (obs_b !== exp_vec(1)) begin
                miscompares++;
                $display("FAIL reset_model_b cyc %0d got %h expected %h", cyc, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_left_sweep();
        logic [2:0] pat[4];
        pat = '{3'b000, 3'b001, 3'b011, 3'b111};
        turn = 1'b1; side = 1'b1; tick = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            vectors++;
            if (st_a !== 3'd2 || (k >= 1 && (ll_a !== pat[(k - 1) % 4] || rl_a !== 3'b000))) begin
                miscompares++;
                $display("FAIL left_sweep k %0d got st=%0d l=%b r=%b expected st=2 l=%b r=000",
                         k, st_a, ll_a, rl_a, pat[(k + 3) % 4]);
            end
            vectors++;
            if (obs_b !== exp_vec(1)) begin
                miscompares++;
                $display("FAIL left_model_b cyc %0d got %h expected %h", cyc, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_hazard();
        logic [2:0] e;
        cycle();
        hazard = 1'b1; brake = 1'b1;
        cycle();
        vectors++;
        if (st_a !== 3'd1) begin
            miscompares++;
            $display("FAIL hazard_enter got state %0d expected 1", st_a);
        end
        for (int j = 1; j <= 8; j++) begin
            cycle();
            e = ((((j - 1) / 2) % 2) == 1) ? 3'b111 : 3'b000;
            vectors++;
            if (ll_a !== e || rl_a !== e) begin
                miscompares++;
                $display("FAIL hazard_blink j %0d got l=%b r=%b expected %b/%b", j, ll_a, rl_a, e, e);
            end
            vectors++;
            if (obs_b !== exp_vec(1)) begin
                miscompares++;
                $display("FAIL hazard_model_b cyc %0d got %h expected %h", cyc, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_direct_switch();
        logic [2:0] pat[4];
        pat = '{3'b000, 3'b100, 3'b110, 3'b111};
        hazard = 1'b0; brake = 1'b0; turn = 1'b1; side = 1'b1; tick = 1'b1;
        repeat (4) cycle();
        side = 1'b0;
        cycle();
        vectors++;
        if (st_a !== 3'd3) begin
            miscompares++;
            $display("FAIL switch_state got %0d expected 3", st_a);
        end
        for (int j = 1; j <= 4; j++) begin
            cycle();
            vectors++;
            if (rl_a !== pat[j - 1] || ll_a !== 3'b000) begin
                miscompares++;
                $display("FAIL switch_sweep j %0d got l=%b r=%b expected l=000 r=%b", j, ll_a, rl_a, pat[j - 1]);
            end
            vectors++;
            if (obs_b !== exp_vec(1)) begin
                miscompares++;
                $display("FAIL switch_model_b cyc %0d got %h expected %h", cyc, obs_b, exp_vec(1));
            end
        end
    endtask

    task automatic test_brake();
        turn = 1'b0; tick = 1'b1;
        cycle();
        tick = 1'b0; brake = 1'b1;
        cycle();
        cycle();
        vectors++;
        if (ll_a !== 3'b111 || rl_a !== 3'b111 || st_a !== 3'd0) begin
            miscompares++;
            $display("FAIL brake_idle got st=%0d l=%b r=%b expected 0 111/111", st_a, ll_a, rl_a);
        end
        turn = 1'b1; side = 1'b0; tick = 1'b1;
        cycle();
        cycle();
        tick = 1'b0;
        cycle();
        vectors++;
        if (ll_a !== 3'b111 || rl_a !== 3'b100) begin
            miscompares++;
            $display("FAIL brake_right got l=%b r=%b expected 111/100", ll_a, rl_a);
        end
        vectors++;
        if (obs_b !== exp_vec(1) || obs_a !== exp_vec(0)) begin
            miscompares++;
            $display("FAIL brake_model cyc %0d got %h/%h expected %h/%h", cyc, obs_a, obs_b, exp_vec(0), exp_vec(1));
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] pat[4];
        pat = '{5'b00000, 5'b10000, 5'b11000, 5'b11100};
        brake = 1'b0; turn = 1'b0; tick = 1'b1;
        cycle();
        turn = 1'b1; side = 1'b0;
        repeat (7) cycle();
        reset_n = 1'b0;
        cycle();
        vectors++;
        if ({st_b, busy_b, ll_b, rl_b, st_a, busy_a, ll_a, rl_a} !== 24'd0) begin
            miscompares++;
            $display("FAIL mid_reset got a=%h b=%h expected all zero", obs_a, obs_b);
        end
        reset_n = 1'b1;
        cycle();
        vectors++;
        if (st_b !== 3'd3) begin
            miscompares++;
            $display("FAIL reentry_state got %0d expected 3", st_b);
        end
        for (int j = 1; j <= 12; j++) begin
            cycle();
            vectors++;
            if (rl_b !== pat[(j - 1) / 3] || ll_b !== 5'b00000) begin
                miscompares++;
                $display("FAIL reentry_sweep j %0d got l=%b r=%b expected l=00000 r=%b", j, ll_b, rl_b, pat[(j - 1) / 3]);
            end
            vectors++;
            if (obs_a !== exp_vec(0)) begin
                miscompares++;
                $display("FAIL reentry_model_a cyc %0d got %h expected %h", cyc, obs_a, exp_vec(0));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            reset_n = ($urandom_range(63) != 0);
            tick    = $urandom_range(1);
            hazard  = ($urandom_range(7) == 0);
            turn    = $urandom_range(1);
            side    = ($urandom_range(15) != 0) ? side : ~side;
            brake   = ($urandom_range(3) == 0);
            cycle();
            vectors++;
            if (obs_a !== exp_vec(0)) begin
                miscompares++;
                $display("FAIL random_a cyc %0d got %h expected %h", cyc, obs_a, exp_vec(0));
            end
            vectors++;
            if (obs_b !== exp_vec(1)) begin
                miscompares++;
                $display("FAIL random_b cyc %0d got %h expected %h", cyc, obs_b, exp_vec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_sweep();
        test_hazard();
        test_direct_switch();
        test_brake();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
